// File: rtl/grf_scoreboard.sv
// Register-file hazard scoreboard: per-register pending-write counters, stall is combinational, state updates 1 cycle after issue/write-back.
// Backpressure: stall holds decode on a RAW hazard or a saturated destination counter; write-back is never blocked.
module grf_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       issue_valid,
  input  logic [4:0] issue_A1,
  input  logic [4:0] issue_A2,
  input  logic       issue_use1,
  input  logic       issue_use2,
  input  logic       issue_WE,
  input  logic [4:0] issue_A3,
  input  logic       wb_WE,
  input  logic [4:0] wb_A3,
  output logic       stall,
  output logic       pending_any,
  output logic [9:0] outstanding,
  output logic       underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Entry 0 is held at zero so $0 always reads as ready.
  logic [CNT_W-1:0] cnt [32];

  logic [CNT_W-1:0] cnt1, cnt2, cnt3, cntw;
  logic             hazard1, hazard2, full, accept;
  logic             inc, wb_hit, same, dec, uflow_ev;
  logic [9:0]       out_next;

  always_comb begin
    cnt1 = cnt[issue_A1];
    cnt2 = cnt[issue_A2];
    cnt3 = cnt[issue_A3];
    cntw = cnt[wb_A3];
  end

  always_comb begin
    hazard1 = issue_use1 & (issue_A1 != 5'd0) & (cnt1 != '0);
    hazard2 = issue_use2 & (issue_A2 != 5'd0) & (cnt2 != '0);
    full    = issue_WE & (issue_A3 != 5'd0) & (cnt3 == CNT_MAX);
    stall   = issue_valid & (hazard1 | hazard2 | full);
    accept  = issue_valid & ~stall;
  end

  // A same-register increment and decrement cancel; the increment is taken
  // first, so a write-back into a zero counter paired with an issue is legal.
  always_comb begin
    inc      = accept & issue_WE & (issue_A3 != 5'd0);
    wb_hit   = wb_WE & (wb_A3 != 5'd0);
    same     = inc & wb_hit & (wb_A3 == issue_A3);
    dec      = wb_hit & ((cntw != '0) | same);
    uflow_ev = wb_hit & (cntw == '0) & ~same;
    out_next = outstanding + 10'(inc) - 10'(dec);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      outstanding <= '0;
      pending_any <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (inc && issue_A3 == 5'(i) && !(dec && wb_A3 == 5'(i)))
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec && wb_A3 == 5'(i) && !(inc && issue_A3 == 5'(i)))
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
      outstanding <= out_next;
      pending_any <= (out_next != 10'd0);
      if (uflow_ev) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard: directed per-cycle vectors push expected outputs; a negedge monitor pops and compares.
module tb_grf_scoreboard;

  logic       clk = 1'b0;
  logic       RESET;
  logic       issue_valid, issue_use1, issue_use2, issue_WE, wb_WE;
  logic [4:0] issue_A1, issue_A2, issue_A3, wb_A3;
  logic       stall, pending_any, underflow;
  logic [9:0] outstanding;

  always #5 clk = ~clk;

  grf_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .RESET(RESET),
    .issue_valid(issue_valid), .issue_A1(issue_A1), .issue_A2(issue_A2),
    .issue_use1(issue_use1), .issue_use2(issue_use2),
    .issue_WE(issue_WE), .issue_A3(issue_A3),
    .wb_WE(wb_WE), .wb_A3(wb_A3),
    .stall(stall), .pending_any(pending_any),
    .outstanding(outstanding), .underflow(underflow)
  );

  typedef struct {
    logic       st;
    logic [9:0] o;
    logic       uf;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: the scoreboard outputs are observed every cycle at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (stall !== e.st) begin
        fails++;
        $display("FAIL %s stall: got %0b expected %0b", e.nm, stall, e.st);
      end
      tests++;
      if (outstanding !== e.o) begin
        fails++;
        $display("FAIL %s outstanding: got %0d expected %0d", e.nm, outstanding, e.o);
      end
      tests++;
      if (pending_any !== (e.o != 10'd0)) begin
        fails++;
        $display("FAIL %s pending_any: got %0b expected %0b", e.nm, pending_any, (e.o != 10'd0));
      end
      tests++;
      if (underflow !== e.uf) begin
        fails++;
        $display("FAIL %s underflow: got %0b expected %0b", e.nm, underflow, e.uf);
      end
    end
  end

  task automatic rand_inputs();
    issue_valid = 1'($urandom); issue_use1 = 1'($urandom); issue_use2 = 1'($urandom);
    issue_WE    = 1'($urandom); wb_WE      = 1'($urandom);
    issue_A1 = 5'($urandom); issue_A2 = 5'($urandom);
    issue_A3 = 5'($urandom); wb_A3    = 5'($urandom);
  endtask

  // One cycle: drive inputs, queue the outputs expected during this cycle.
  task automatic step(input logic iv, input logic u1, input logic [4:0] a1,
                      input logic u2, input logic [4:0] a2,
                      input logic we, input logic [4:0] a3,
                      input logic wwe, input logic [4:0] wa3,
                      input logic es, input logic [9:0] eo, input logic eu,
                      input string nm);
    exp_t e;
    RESET = 1'b0;
    issue_valid = iv; issue_use1 = u1; issue_A1 = a1;
    issue_use2 = u2; issue_A2 = a2;
    issue_WE = we; issue_A3 = a3;
    wb_WE = wwe; wb_A3 = wa3;
    e.st = es; e.o = eo; e.uf = eu; e.nm = nm;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    RESET = 1'b1;
    rand_inputs();
    @(posedge clk); #1;
    rand_inputs();
    @(posedge clk); #1;

    //   iv u1 a1  u2 a2  we a3  wwe wa3  stall out uf
    step(0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0, 0, "reset_state");
    // RAW on $8
    step(1, 0, 0,  0, 0,  1, 8,  0, 0,   0, 0, 0, "raw_issue_w8");
    step(1, 1, 8,  0, 0,  0, 0,  0, 0,   1, 1, 0, "raw_stall");
    step(1, 1, 8,  0, 0,  0, 0,  1, 8,   1, 1, 0, "raw_stall_wb_cycle");
    step(1, 1, 8,  0, 0,  0, 0,  0, 0,   0, 0, 0, "raw_release");
    // Register 0
    step(1, 0, 0,  0, 0,  1, 0,  0, 0,   0, 0, 0, "r0_write");
    step(1, 1, 0,  1, 0,  0, 0,  0, 0,   0, 0, 0, "r0_read");
    step(0, 0, 0,  0, 0,  0, 0,  1, 0,   0, 0, 0, "r0_wb");
    step(0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0, 0, "r0_no_underflow");
    // Saturation on $5
    step(1, 0, 0,  0, 0,  1, 5,  0, 0,   0, 0, 0, "sat_w1");
    step(1, 0, 0,  0, 0,  1, 5,  0, 0,   0, 1, 0, "sat_w2");
    step(1, 0, 0,  0, 0,  1, 5,  0, 0,   0, 2, 0, "sat_w3");
    step(1, 0, 0,  0, 0,  1, 5,  0, 0,   1, 3, 0, "sat_full");
    step(1, 0, 0,  0, 0,  1, 5,  1, 5,   1, 3, 0, "sat_full_wb_cycle");
    step(1, 0, 0,  0, 0,  1, 5,  0, 0,   0, 2, 0, "sat_accept");
    step(0, 0, 0,  0, 0,  0, 0,  1, 5,   0, 3, 0, "sat_drain3");
    step(0, 0, 0,  0, 0,  0, 0,  1, 5,   0, 2, 0, "sat_drain2");
    step(0, 0, 0,  0, 0,  0, 0,  1, 5,   0, 1, 0, "sat_drain1");
    // Source 2 hazard, use-bit masking
    step(1, 0, 0,  0, 0,  1, 9,  0, 0,   0, 0, 0, "h2_w9");
    step(1, 1, 3,  1, 9,  0, 0,  0, 0,   1, 1, 0, "h2_stall");
    step(1, 0, 9,  0, 9,  0, 0,  0, 0,   0, 1, 0, "unused_src");
    // Same-register issue and write-back
    step(1, 0, 0,  0, 0,  1, 9,  1, 9,   0, 1, 0, "sim_cnt1");
    step(1, 1, 9,  0, 0,  0, 0,  0, 0,   1, 1, 0, "sim_cnt1_kept");
    step(0, 0, 0,  0, 0,  0, 0,  1, 9,   0, 1, 0, "sim_drain9");
    step(1, 0, 0,  0, 0,  1, 9,  1, 9,   0, 0, 0, "sim_cnt0");
    step(1, 1, 9,  0, 0,  0, 0,  0, 0,   0, 0, 0, "sim_cnt0_no_uf");
    // Different registers in the same cycle
    step(1, 0, 0,  0, 0,  1, 10, 0, 0,   0, 0, 0, "diff_w10");
    step(1, 0, 0,  0, 0,  1, 11, 1, 10,  0, 1, 0, "diff_w11_wb10");
    step(1, 1, 10, 1, 11, 0, 0,  0, 0,   1, 1, 0, "diff_h11");
    step(1, 1, 10, 0, 0,  0, 0,  0, 0,   0, 1, 0, "diff_r10_ready");
    step(0, 0, 0,  0, 0,  0, 0,  1, 11,  0, 1, 0, "diff_drain11");
    // Underflow is sticky
    step(0, 0, 0,  0, 0,  0, 0,  1, 12,  0, 0, 0, "uf_event");
    step(1, 0, 0,  0, 0,  1, 12, 0, 0,   0, 0, 1, "uf_set");
    step(0, 0, 0,  0, 0,  0, 0,  1, 12,  0, 1, 1, "uf_sticky1");
    step(0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0, 1, "uf_sticky2");
    // No stall without issue_valid
    step(1, 0, 0,  0, 0,  1, 7,  0, 0,   0, 0, 1, "nv_w7");
    step(0, 1, 7,  0, 0,  0, 0,  0, 0,   0, 1, 1, "nv_no_stall");

    // Mid-run reset beats concurrent issue and write-back
    RESET = 1'b1;
    issue_valid = 1'b1; issue_WE = 1'b1; issue_A3 = 5'd7;
    wb_WE = 1'b1; wb_A3 = 5'd7;
    @(posedge clk); #1;
    step(0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0, 0, "mid_reset");
    step(0, 0, 0,  0, 0,  0, 0,  1, 7,   0, 0, 0, "stale_wb");
    step(1, 1, 7,  0, 0,  0, 0,  0, 0,   0, 0, 1, "stale_wb_uf");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Read-side hazard tracker for the general register file in the pipelined MIPS core. It counts in-flight writes per architectural register, issued at decode and retired at write-back. It stalls any decoding instruction whose source registers, or its own destination counter, are not ready. Its write-back inputs are the same `WE`/`A3` pair driven into the register file, so it sits beside the register file at the decode/write-back boundary.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter. Maximum outstanding writes per register is 2^CNT_W − 1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `RESET`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `issue_valid`, input, 1: the decode stage presents an instruction this cycle.
- `issue_A1`, input, 5: first source register.
- `issue_A2`, input, 5: second source register.
- `issue_use1`, input, 1: the instruction reads `issue_A1`.
- `issue_use2`, input, 1: the instruction reads `issue_A2`.
- `issue_WE`, input, 1: the instruction will write a register.
- `issue_A3`, input, 5: destination register.
- `wb_WE`, input, 1: write-back strobe; same signal as the register file `WE`.
- `wb_A3`, input, 5: write-back destination; same signal as the register file `A3`.
- `stall`, output, 1: combinational; the decode instruction must hold this cycle.
- `pending_any`, output, 1: registered; at least one counter is nonzero.
- `outstanding`, output, 10: registered; sum of all counters.
- `underflow`, output, 1: registered and sticky; a write-back arrived for a register whose counter was 0.

## Operation
- State consists of 31 counters, `cnt[1..31]`, each CNT_W bits wide. Register 0 has no counter; it always reads as ready and is never counted.
- `hazard1 = issue_use1 & (issue_A1 != 0) & (cnt[issue_A1] != 0)`. `hazard2` is the same expression on `A2`.
- `full = issue_WE & (issue_A3 != 0) & (cnt[issue_A3] == 2^CNT_W−1)`.
- `stall = issue_valid & (hazard1 | hazard2 | full)`.
- `accept = issue_valid & ~stall`. On accept with `issue_WE & issue_A3 != 0`, `cnt[issue_A3]` increments.
- On `wb_WE & wb_A3 != 0`:
  - If `cnt[wb_A3] != 0`, it decrements.
  - If `cnt[wb_A3] == 0`, the counter stays 0 and `underflow` sets.
- An increment and a decrement to the same register in the same cycle cancel, and the count is unchanged. If that counter was 0, `underflow` does not set: the increment is logically applied first.
- An increment and a decrement on different registers in the same cycle are applied independently.
- `outstanding` equals the sum of all `cnt` values and is maintained incrementally: +1 on a counted accept, −1 on a valid decrement, no change when both occur. `pending_any = (outstanding != 0)`.
- `underflow` clears only on `RESET`.
- The block performs no forwarding. A source whose write-back occurs in the current cycle still stalls, because the register file write is visible at the next edge.

## Timing
- `stall` is purely combinational from the issue inputs and the current counters. It has no dependence on `wb_*` in the same cycle.
- Counters, `outstanding`, `pending_any` and `underflow` update on the rising edge. A stall caused by a pending register releases in the cycle after the write-back edge that zeroes its counter.
- Reset values:
  - All `cnt` = 0, `outstanding` = 0, `pending_any` = 0, `underflow` = 0.
  - `stall` = 0, since all counters are 0 and the full condition is impossible.
- `RESET` asserted mid-operation has priority over all issue and write-back activity in that cycle. Any later write-backs from pre-reset instructions count as underflow; the pipeline must be flushed together with the scoreboard.
- Latency: write-back to ready is 1 cycle. Issue to counted is 1 cycle.

## Test plan
- **Reset:** hold `RESET` 2 cycles with random inputs, then `issue_valid`=0 → `stall`=0, `outstanding`=0, `pending_any`=0, `underflow`=0.
- **RAW stall:** issue WE=1, A3=8; next cycle issue use1=1, A1=8 → `stall`=1.
  - `wb_WE`=1, `wb_A3`=8 in cycle N → `stall` stays 1 in cycle N and is 0 in cycle N+1.
  - `outstanding` goes 1 → 0.
- **Register 0:** issue WE=1, A3=0, then use1=1, A1=0 → no stall, `outstanding`=0. A write-back to `$0` never sets `underflow`.
- **Saturation (CNT_W=2):**
  - Three accepted writes to `$5` → `cnt[5]`=3, `outstanding`=3.
  - A fourth issue with WE=1, A3=5 → `stall`=1.
  - One write-back to `$5` → the fourth issue is accepted on the next cycle.
- **Simultaneous events:**
  - With `cnt[9]`=1, accept WE, A3=9 and write-back `wb_A3`=9 in the same cycle → `cnt[9]` stays 1, `outstanding` unchanged.
  - With `cnt[9]`=0, the same pairing → `cnt[9]`=0 and `underflow`=0.
- **Underflow:** write-back `wb_A3`=12 while `cnt[12]`=0 → `underflow`=1 next cycle and remains 1 through further traffic until `RESET`.
